// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the KxK streaming convolution.
package conv_pkg;

  // Control states of the kernel-load / streaming sequencer
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } conv_state_e;

  // Supported kernel side lengths
  localparam int KSIZE_SMALL = 3;
  localparam int KSIZE_LARGE = 5;

  // Output saturation ceiling (unsigned 8-bit pixel)
  localparam int CLAMP_MAX = 255;

  // Fixed field widths of the coefficient and shift inputs
  localparam int COEFW  = 8;
  localparam int SHIFTW = 4;

  // True when k is one of the supported kernel side lengths
  function automatic bit ksize_legal(input int k);
    return (k == KSIZE_SMALL) || (k == KSIZE_LARGE);
  endfunction

endpackage

// File: rtl/conv_sat_u8.sv
// conv_sat_u8: combinational output stage -- arithmetic shift (optionally
// rounded), absolute-value or negative-to-zero clamp, saturation to 255.
// Optional macro CONV_ROUND_EN: add 2^(shift-1) before shifting (round half up).
module conv_sat_u8
  import conv_pkg::*;
#(
  parameter int ACCW = 24
) (
  input  logic signed [ACCW-1:0]   sum_i,
  input  logic        [SHIFTW-1:0] shift_i,
  input  logic                     abs_mode_i,
  output logic        [7:0]        pix_o
);

  // One extra bit keeps the rounding add and the negation free of overflow
  logic signed [ACCW:0] wide;
  logic signed [ACCW:0] rnd;
  logic signed [ACCW:0] t;
  logic signed [ACCW:0] mag;

  // Shift, rectify and saturate the accumulated sum
  always_comb begin
    wide = {sum_i[ACCW-1], sum_i};
`ifdef CONV_ROUND_EN
    rnd  = (shift_i != '0) ? ((ACCW+1)'(1) <<< (shift_i - SHIFTW'(1))) : '0;
`else
    rnd  = '0;
`endif
    t = (wide + rnd) >>> shift_i;
    if (t[ACCW]) begin
      mag = abs_mode_i ? -t : '0;
    end else begin
      mag = t;
    end
    if (mag > (ACCW+1)'(CLAMP_MAX)) begin
      pix_o = 8'(CLAMP_MAX);
    end else begin
      pix_o = mag[7:0];
    end
  end

endmodule

// File: rtl/conv_kxk_stream.sv
// conv_kxk_stream: streaming KxK convolution with a loadable signed kernel.
// Three-stage pipeline (products, sum, shift/clamp) with valid/ready flow
// control; kernel reload drains the pipeline first so in-flight windows keep
// the kernel they were accepted with.
// Optional macro CONV_ROUND_EN (used in conv_sat_u8): round half up in S3.
module conv_kxk_stream
  import conv_pkg::*;
#(
  parameter int KSIZE = 3,
  parameter int BITW  = 8,
  parameter int ACCW  = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          k_load,
  input  logic                          k_valid,
  input  logic [COEFW-1:0]              k_data,
  output logic                          k_busy,
  input  logic [SHIFTW-1:0]             shift,
  input  logic                          abs_mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [KSIZE*KSIZE*BITW-1:0]   win,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_pix
);

  localparam int KK   = KSIZE * KSIZE;
  localparam int CNTW = $clog2(KK);

  conv_state_e state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            coef_we;
  logic            last_word;
  logic            advance;
  logic            accept;
  logic            pipe_empty;

  logic signed [COEFW-1:0] coef_q [KK];
  logic signed [ACCW-1:0]  prod_d [KK];
  logic signed [ACCW-1:0]  prod_q [KK];

  logic              s1_valid_q;
  logic [SHIFTW-1:0] s1_shift_q;
  logic              s1_abs_q;
  logic signed [ACCW-1:0] sum_d, sum_q;
  logic              s2_valid_q;
  logic [SHIFTW-1:0] s2_shift_q;
  logic              s2_abs_q;
  logic              out_valid_q;
  logic [7:0]        out_pix_q;
  logic [7:0]        sat_pix;

  // The whole pipeline moves only when the output slot is free or being taken
  assign advance    = ~out_valid_q | out_ready;
  assign accept     = in_valid & in_ready;
  assign last_word  = coef_we & (cnt_q == CNTW'(KK - 1));
  assign pipe_empty = ~s1_valid_q & ~s2_valid_q & ~out_valid_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: reload requests are only honoured from IDLE and RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (k_load)     state_d = ST_LOAD;
      ST_LOAD:  if (last_word)  state_d = ST_RUN;
      ST_RUN:   if (k_load)     state_d = ST_DRAIN;
      ST_DRAIN: if (pipe_empty) state_d = ST_LOAD;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs: windows only in RUN, coefficients only in LOAD
  always_comb begin
    k_busy   = 1'b1;
    in_ready = 1'b0;
    coef_we  = 1'b0;
    case (state_q)
      ST_RUN: begin
        k_busy   = 1'b0;
        in_ready = advance;
      end
      ST_LOAD: coef_we = k_valid;
      default: ;
    endcase
  end

  // Load counter restarts at zero whenever LOAD is (re)entered
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != ST_LOAD)  cnt_d = '0;
    else if (last_word)      cnt_d = '0;
    else if (coef_we)        cnt_d = cnt_q + 1'b1;
  end

  // Load counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Coefficient bank: the n-th accepted word lands in slot n (row-major)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KK; i++) coef_q[i] <= '0;
    end else if (coef_we) begin
      coef_q[cnt_q] <= k_data;
    end
  end

  // One multiplier per tap; pixels are unsigned so they get a zero sign bit
  for (genvar gi = 0; gi < KK; gi++) begin : g_mul
    logic signed [BITW:0]   pix_se;
    logic signed [ACCW-1:0] pix_ext;
    logic signed [ACCW-1:0] coef_ext;
    assign pix_se     = {1'b0, win[gi*BITW +: BITW]};
    assign pix_ext    = ACCW'(pix_se);
    assign coef_ext   = ACCW'(coef_q[gi]);
    assign prod_d[gi] = pix_ext * coef_ext;
  end

  // S1: register products together with the window's own shift/abs settings
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_shift_q <= '0;
      s1_abs_q   <= 1'b0;
      for (int i = 0; i < KK; i++) prod_q[i] <= '0;
    end else if (advance) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_shift_q <= shift;
        s1_abs_q   <= abs_mode;
        for (int i = 0; i < KK; i++) prod_q[i] <= prod_d[i];
      end
    end
  end

  // Adder tree over all registered products
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < KK; i++) sum_d = sum_d + prod_q[i];
  end

  // S2: register the sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_shift_q <= '0;
      s2_abs_q   <= 1'b0;
      sum_q      <= '0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sum_q      <= sum_d;
        s2_shift_q <= s1_shift_q;
        s2_abs_q   <= s1_abs_q;
      end
    end
  end

  conv_sat_u8 #(
    .ACCW (ACCW)
  ) u_sat (
    .sum_i      (sum_q),
    .shift_i    (s2_shift_q),
    .abs_mode_i (s2_abs_q),
    .pix_o      (sat_pix)
  );

  // S3: output register, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
    end else if (advance) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) out_pix_q <= sat_pix;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;

endmodule

// File: tb/tb_conv_kxk_stream.sv
// Testbench for conv_kxk_stream: directed cases plus randomized streams,
// checked against a plain-arithmetic convolution model and a result queue.
// Optional macro CONV_ROUND_EN selects the rounding variant of the model.
`timescale 1ns/1ps
module tb_conv_kxk_stream;

  localparam int K   = 3;
  localparam int KK  = K * K;
  localparam int BW  = 8;
  localparam int AW  = 24;
  localparam int KK5 = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            k_load, k_valid, k_busy;
  logic [7:0]      k_data;
  logic [3:0]      shift;
  logic            abs_mode, in_valid, in_ready;
  logic [KK*BW-1:0] win;
  logic            out_valid, out_ready;
  logic [7:0]      out_pix;

  logic            k5_load, k5_valid, k5_busy;
  logic [7:0]      k5_data;
  logic            k5_in_valid, k5_in_ready, k5_out_valid;
  logic [KK5*BW-1:0] k5_win;
  logic [7:0]      k5_out_pix;

  conv_kxk_stream #(.KSIZE(3), .BITW(8), .ACCW(24)) dut (
    .clk(clk), .rst_n(rst_n), .k_load(k_load), .k_valid(k_valid), .k_data(k_data),
    .k_busy(k_busy), .shift(shift), .abs_mode(abs_mode), .in_valid(in_valid),
    .in_ready(in_ready), .win(win), .out_valid(out_valid), .out_ready(out_ready),
    .out_pix(out_pix)
  );

  conv_kxk_stream #(.KSIZE(5), .BITW(8), .ACCW(24)) dut5 (
    .clk(clk), .rst_n(rst_n), .k_load(k5_load), .k_valid(k5_valid), .k_data(k5_data),
    .k_busy(k5_busy), .shift(4'd0), .abs_mode(1'b0), .in_valid(k5_in_valid),
    .in_ready(k5_in_ready), .win(k5_win), .out_valid(k5_out_valid), .out_ready(1'b1),
    .out_pix(k5_out_pix)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  int last_out = -1;
  int kern [KK];
  int exp_q [$];
  bit hold_pend = 1'b0;
  int hold_pix = 0;
  int rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 held low

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: direct dot product, floor shift, rectify, saturate
  function automatic int ref_pix(input logic [KK*BW-1:0] w, input int sh, input bit ab);
    longint s = 0;
    for (int i = 0; i < KK; i++) s += longint'(w[i*BW +: BW]) * kern[i];
`ifdef CONV_ROUND_EN
    if (sh > 0) s += longint'(1) << (sh - 1);
`endif
    s = s >>> sh;
    if (s < 0) s = ab ? -s : 0;
    if (s > 255) s = 255;
    return int'(s);
  endfunction

  function automatic logic [KK*BW-1:0] fill(input int v);
    logic [KK*BW-1:0] w;
    for (int i = 0; i < KK; i++) w[i*BW +: BW] = 8'(v);
    return w;
  endfunction

  function automatic logic [KK*BW-1:0] rand_win();
    logic [KK*BW-1:0] w;
    for (int i = 0; i < KK; i++) w[i*BW +: BW] = 8'($urandom);
    return w;
  endfunction

  // Monitor: scoreboard pushes on accept, pops on output handshake, hold check
  always @(negedge clk) begin
    if (hold_pend) begin
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_pix", out_pix, hold_pix);
    end
    hold_pend = out_valid && !out_ready;
    hold_pix  = out_pix;
    if (in_valid && in_ready) exp_q.push_back(ref_pix(win, shift, abs_mode));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", out_valid, 0);
      end else begin
        int e;
        e = exp_q.pop_front();
        $display("out %0d: pix=%0d expected=%0d", n_out, out_pix, e);
        check_eq("result", out_pix, e);
        last_out = out_pix;
        n_out++;
      end
    end
  end

  // Downstream ready pattern
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 500 && exp_q.size() > 0; i++) @(negedge clk);
    check_eq("drain_left", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic send_window(input logic [KK*BW-1:0] w, input int sh, input bit ab);
    bit ok = 1'b0;
    win = w; shift = 4'(sh); abs_mode = ab; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("accepted", ok, 1);
  endtask

  // Reload: request, drain, then words with random gaps and an ignored k_load
  task automatic load_kernel(input int vals [KK]);
    k_load = 1'b1; @(posedge clk); #1; k_load = 1'b0;
    @(negedge clk);
    check_eq("ld_in_ready", in_ready, 0);
    check_eq("ld_busy", k_busy, 1);
    rdy_mode = 0;
    wait_drain();
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < KK; i++) begin
      if (i == 4) begin
        k_load = 1'b1; @(posedge clk); #1; k_load = 1'b0;
        check_eq("ld_busy_mid", k_busy, 1);
      end
      if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
      k_valid = 1'b1; k_data = 8'(vals[i]);
      @(posedge clk); #1;
      k_valid = 1'b0;
    end
    kern = vals;
    @(negedge clk);
    check_eq("ld_run", k_busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_one(input logic [KK*BW-1:0] w, input int sh, input bit ab,
                         input int want, input string tag);
    send_window(w, sh, ab);
    @(negedge clk); check_eq({tag, "_lat1"}, out_valid, 0);
    @(negedge clk); check_eq({tag, "_lat2"}, out_valid, 0);
    @(negedge clk); check_eq({tag, "_lat3"}, out_valid, 1);
    wait_drain();
    check_eq(tag, last_out, want);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones [KK];
    int lap [KK];
    int kv [KK];
    logic [KK*BW-1:0] w;
    int base;

    rst_n = 1'b0; k_load = 0; k_valid = 0; k_data = 0; shift = 0; abs_mode = 0;
    in_valid = 0; win = '0;
    k5_load = 0; k5_valid = 0; k5_data = 0; k5_in_valid = 0; k5_win = '0;
    for (int i = 0; i < KK; i++) begin ones[i] = 1; lap[i] = -1; end
    lap[4] = 8;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_pix", out_pix, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_k_busy", k_busy, 1);
    check_eq("rst_k5_busy", k5_busy, 1);
    @(posedge clk); #1; rst_n = 1'b1;

    // Stray coefficient strobe in IDLE must not count toward the load
    k_valid = 1'b1; k_data = 8'd77; @(posedge clk); #1; k_valid = 1'b0;
    @(negedge clk); check_eq("idle_busy", k_busy, 1);
    @(posedge clk); #1;

    // 5x5 instance: all-ones kernel, flat window of 10
    k5_load = 1'b1; @(posedge clk); #1; k5_load = 1'b0;
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < KK5; i++) begin
      k5_valid = 1'b1; k5_data = 8'd1; @(posedge clk); #1;
    end
    k5_valid = 1'b0;
    for (int i = 0; i < KK5; i++) k5_win[i*BW +: BW] = 8'd10;
    k5_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (k5_in_ready) break; end
    @(posedge clk); #1; k5_in_valid = 1'b0;
    for (int i = 0; i < 20 && !k5_out_valid; i++) @(negedge clk);
    check_eq("k5_valid", k5_out_valid, 1);
    check_eq("k5_sum", k5_out_pix, 250);
    $display("k5 window: pix=%0d expected=250", k5_out_pix);

    // Directed 3x3 cases
    load_kernel(ones);
    run_one(fill(10), 0, 1'b0, 90, "flat10");
    load_kernel(lap);
    w = fill(255); w[4*BW +: BW] = 8'd0;
    run_one(w, 0, 1'b1, 255, "lap_abs");
    run_one(w, 0, 1'b0, 0, "lap_neg0");
    load_kernel(ones);
    run_one(fill(255), 3, 1'b0, 255, "sat286");
`ifdef CONV_ROUND_EN
    run_one(fill(20), 3, 1'b0, 23, "round20");
`else
    run_one(fill(20), 3, 1'b0, 22, "trunc20");
`endif

    // Ten windows with out_ready toggling
    rdy_mode = 1;
    base = n_out;
    for (int i = 0; i < 10; i++) send_window(rand_win(), $urandom_range(0, 4), 1'($urandom));
    wait_drain();
    check_eq("toggle_count", n_out - base, 10);
    rdy_mode = 0;

    // Random kernel, random backpressure, stray k_valid in RUN
    for (int i = 0; i < KK; i++) kv[i] = int'($urandom_range(0, 255)) - 128;
    load_kernel(kv);
    rdy_mode = 2;
    base = n_out;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        k_valid = 1'b1; k_data = 8'($urandom); @(posedge clk); #1; k_valid = 1'b0;
      end
      send_window(rand_win(), $urandom_range(0, 12), 1'($urandom));
    end
    wait_drain();
    check_eq("rand_count", n_out - base, 60);
    rdy_mode = 0;

    // Reload with two windows in flight; next result must use the new kernel
    rdy_mode = 3; out_ready = 1'b0;
    base = n_out;
    send_window(rand_win(), 2, 1'b1);
    send_window(rand_win(), 2, 1'b0);
    @(negedge clk); @(negedge clk);
    check_eq("inflight_valid", out_valid, 1);
    for (int i = 0; i < KK; i++) kv[i] = int'($urandom_range(0, 255)) - 128;
    load_kernel(kv);
    check_eq("inflight_count", n_out - base, 2);
    send_window(rand_win(), 1, 1'b1);
    wait_drain();
    check_eq("newk_count", n_out - base, 3);

    // Reset with two windows in flight
    rdy_mode = 3; out_ready = 1'b0;
    send_window(rand_win(), 0, 1'b0);
    send_window(rand_win(), 0, 1'b0);
    @(negedge clk); @(negedge clk);
    check_eq("rst_inflight", out_valid, 1);
    @(posedge clk); #2;
    rst_n = 1'b0; exp_q.delete(); hold_pend = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_pix", out_pix, 0);
    @(posedge clk); #1; rst_n = 1'b1; rdy_mode = 0;
    win = rand_win(); in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("post_rst_valid", out_valid, 0);
      check_eq("post_rst_busy", k_busy, 1);
      check_eq("post_rst_ready", in_ready, 0);
    end
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
